// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer: serial packet receiver and frame checker.
// Assembles 8 DATA + 1 CMD packets and flags data/CRC/opcode errors.
module mtm_alu_deserializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [2:0]  op_out,
  output logic        data_valid,
  output logic [2:0]  err_flags,
  output logic        err_valid
);

  localparam logic [2:0] ERR_DATA = 3'b100;
  localparam logic [2:0] ERR_CRC  = 3'b010;
  localparam logic [2:0] ERR_OP   = 3'b001;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    STOP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  bit_cnt;
  logic [8:0]  shreg;
  logic        armed;
  logic [63:0] opnd;
  logic [3:0]  dcnt;
  logic        drop;

  logic        pkt_cmd;
  logic [7:0]  payload;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_crc;
  logic [67:0] crc_msg;
  logic [3:0]  crc_calc;
  logic        op_ok;

  assign pkt_cmd = shreg[8];
  assign payload = shreg[7:0];
  assign cmd_op  = shreg[6:4];
  assign cmd_crc = shreg[3:0];
  assign crc_msg = {opnd, 1'b1, cmd_op};

  // Bit-level state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Bit-level next state: start, 9 shifted bits, stop
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (armed && !sin) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == 4'd8) state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift type and payload bits, MSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        SHIFT: begin
          shreg   <= {shreg[7:0], sin};
          bit_cnt <= bit_cnt + 4'd1;
        end
        default: bit_cnt <= '0;
      endcase
    end
  end

  // Arm on a high line; a bad stop bit disarms
  always_ff @(posedge clk) begin
    if (rst)                armed <= 1'b0;
    else if (state == STOP) armed <= sin;
    else if (sin)           armed <= 1'b1;
  end

  // CRC x^4+x+1 over {B, A, 1, op}, MSB first
  always_comb begin
    logic fb;
    fb       = 1'b0;
    crc_calc = '0;
    for (int i = 67; i >= 0; i--) begin
      fb       = crc_calc[3] ^ crc_msg[i];
      crc_calc = {crc_calc[2:0], 1'b0}
               ^ {2'b00, fb, fb};
    end
  end

  // Opcode legality
  always_comb begin
    op_ok = 1'b0;
    unique case (cmd_op)
      3'b000, 3'b001,
      3'b100, 3'b101: op_ok = 1'b1;
      default:        op_ok = 1'b0;
    endcase
  end

  // Frame tracking and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      opnd       <= '0;
      dcnt       <= '0;
      drop       <= 1'b0;
      a_out      <= '0;
      b_out      <= '0;
      op_out     <= '0;
      data_valid <= 1'b0;
      err_flags  <= '0;
      err_valid  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      err_valid  <= 1'b0;
      if (state == STOP) begin
        if (!sin) begin
          if (!drop) begin
            err_valid <= 1'b1;
            err_flags <= ERR_DATA;
          end
          dcnt <= '0;
          drop <= 1'b0;
        end else if (!pkt_cmd) begin
          if (dcnt != 4'd8) begin
            opnd <= {opnd[55:0], payload};
            dcnt <= dcnt + 4'd1;
          end else begin
            err_valid <= 1'b1;
            err_flags <= ERR_DATA;
            drop      <= 1'b1;
          end
        end else if (drop) begin
          drop <= 1'b0;
          dcnt <= '0;
        end else begin
          dcnt <= '0;
          if (dcnt != 4'd8) begin
            err_valid <= 1'b1;
            err_flags <= ERR_DATA;
          end else if (crc_calc != cmd_crc) begin
            err_valid <= 1'b1;
            err_flags <= ERR_CRC;
          end else if (!op_ok) begin
            err_valid <= 1'b1;
            err_flags <= ERR_OP;
          end else begin
            data_valid <= 1'b1;
            b_out      <= opnd[63:32];
            a_out      <= opnd[31:0];
            op_out     <= cmd_op;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// tb_mtm_alu_deserializer: directed frames against a packet-level model.
// Outputs are compared every cycle on the falling edge.
module tb_mtm_alu_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic [2:0]  op_out;
  logic        data_valid;
  logic [2:0]  err_flags;
  logic        err_valid;

  mtm_alu_deserializer dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .a_out      (a_out),
    .b_out      (b_out),
    .op_out     (op_out),
    .data_valid (data_valid),
    .err_flags  (err_flags),
    .err_valid  (err_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned at_cyc;
    bit          is_cmd;
    logic [7:0]  pl;
    bit          stop_ok;
  } pkt_t;

  pkt_t        pkt_q[$];
  int unsigned cyc = 0;
  int          n_pass = 0;
  int          n_total = 0;
  int          dv_cnt = 0;
  int          ev_cnt = 0;
  int unsigned dv_cyc[$];
  bit          chk_on = 1'b0;

  logic [63:0] m_opnd;
  int          m_cnt;
  bit          m_drop;
  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic [2:0]  exp_op;
  logic [2:0]  exp_err;
  logic        exp_dv;
  logic        exp_ev;

  task automatic chk(input string name,
                     input logic [79:0] got,
                     input logic [79:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, got, exp);
  endtask

  // CRC as remainder of M(x)*x^4 divided by x^4+x+1
  function automatic logic [3:0] crc_model(
    input logic [31:0] b,
    input logic [31:0] a,
    input logic [2:0]  op);
    logic [71:0] m;
    m = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction

  function automatic bit op_valid(input logic [2:0] op);
    return op inside {3'b000, 3'b001, 3'b100, 3'b101};
  endfunction

  task automatic model_reset();
    m_opnd  = '0;
    m_cnt   = 0;
    m_drop  = 0;
    exp_a   = '0;
    exp_b   = '0;
    exp_op  = '0;
    exp_err = '0;
  endtask

  task automatic raise(input logic [2:0] code);
    exp_ev  = 1'b1;
    exp_err = code;
  endtask

  task automatic apply(input pkt_t p);
    logic [2:0] op;
    op = p.pl[6:4];
    if (!p.stop_ok) begin
      if (!m_drop) raise(3'b100);
      m_cnt  = 0;
      m_drop = 0;
    end else if (!p.is_cmd) begin
      if (m_cnt < 8) begin
        m_opnd = {m_opnd[55:0], p.pl};
        m_cnt++;
      end else begin
        raise(3'b100);
        m_drop = 1;
      end
    end else if (m_drop) begin
      m_drop = 0;
      m_cnt  = 0;
    end else begin
      if (m_cnt != 8)
        raise(3'b100);
      else if (crc_model(m_opnd[63:32], m_opnd[31:0], op)
               != p.pl[3:0])
        raise(3'b010);
      else if (!op_valid(op))
        raise(3'b001);
      else begin
        exp_dv = 1'b1;
        exp_b  = m_opnd[63:32];
        exp_a  = m_opnd[31:0];
        exp_op = op;
      end
      m_cnt = 0;
    end
  endtask

  initial begin
    model_reset();
    exp_dv = 0;
    exp_ev = 0;
    forever begin
      @(posedge clk);
      cyc++;
      exp_dv = 0;
      exp_ev = 0;
      if (rst) begin
        model_reset();
        pkt_q.delete();
      end else begin
        while (pkt_q.size() != 0 && pkt_q[0].at_cyc == cyc)
          apply(pkt_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("outputs",
            {8'h0, data_valid, err_valid, a_out, b_out,
             op_out, err_flags},
            {8'h0, exp_dv, exp_ev, exp_a, exp_b,
             exp_op, exp_err});
        if (data_valid) begin
          dv_cnt++;
          dv_cyc.push_back(cyc);
        end
        if (err_valid) ev_cnt++;
      end
    end
  end

  task automatic drive(input logic b);
    @(negedge clk);
    sin = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1);
  endtask

  task automatic pkt(input bit t, input logic [7:0] p,
                     input bit ok);
    drive(1'b0);
    drive(t);
    for (int i = 7; i >= 0; i--) drive(p[i]);
    @(negedge clk);
    sin = ok;
    pkt_q.push_back(pkt_t'{at_cyc: cyc + 1, is_cmd: t,
                           pl: p, stop_ok: ok});
  endtask

  task automatic frame(input logic [31:0] b,
                       input logic [31:0] a,
                       input logic [7:0]  cmd);
    for (int i = 3; i >= 0; i--) pkt(1'b0, b[i*8 +: 8], 1'b1);
    for (int i = 3; i >= 0; i--) pkt(1'b0, a[i*8 +: 8], 1'b1);
    pkt(1'b1, cmd, 1'b1);
  endtask

  task automatic settle();
    idle(3);
    #1;
  endtask

  initial begin
    logic [3:0] c;
    rst = 1'b1;
    sin = 1'b0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    rst = 1'b0;
    repeat (6) drive(1'b0);
    idle(3);
    #1;
    chk("crc_and", {76'h0, crc_model(0, 0, 3'b000)}, 80'hB);
    chk("crc_add", {76'h0, crc_model(0, 0, 3'b100)}, 80'h7);
    chk("crc_bad_op", {76'h0, crc_model(0, 0, 3'b111)}, 80'h2);
    chk("no_start_low", {48'h0, dv_cnt, ev_cnt}, 80'h0);

    frame(0, 0, 8'h0B);
    settle();
    chk("and_frame", {48'h0, dv_cnt, ev_cnt},
        {48'h0, 32'd1, 32'd0});
    chk("and_op", {77'h0, op_out}, 80'h0);

    frame(0, 0, 8'h47);
    frame(0, 0, 8'h47);
    settle();
    chk("add_b2b_cnt", {48'h0, dv_cnt}, 80'd3);
    chk("add_b2b_gap", {48'h0, dv_cyc[2] - dv_cyc[1]}, 80'd99);
    chk("add_op", {77'h0, op_out}, 80'h4);

    frame(0, 0, 8'h72);
    settle();
    chk("bad_op", {45'h0, err_flags, ev_cnt},
        {45'h0, 3'b001, 32'd1});

    c = crc_model(32'hDEADBEEF, 32'h12345678, 3'b101);
    frame(32'hDEADBEEF, 32'h12345678, {4'b0101, c});
    settle();
    chk("sub_ops", {13'h0, a_out, b_out, op_out},
        {13'h0, 32'h12345678, 32'hDEADBEEF, 3'b101});

    frame(0, 0, 8'h04);
    settle();
    chk("crc_err", {45'h0, err_flags, a_out},
        {45'h0, 3'b010, 32'h12345678});

    for (int i = 0; i < 5; i++) pkt(1'b0, 8'(i), 1'b1);
    pkt(1'b1, 8'h0B, 1'b1);
    settle();
    chk("short", {45'h0, err_flags, ev_cnt},
        {45'h0, 3'b100, 32'd3});

    for (int i = 0; i < 9; i++) pkt(1'b0, 8'hA5, 1'b1);
    pkt(1'b1, 8'h0B, 1'b1);
    settle();
    chk("nine_data", {48'h0, dv_cnt, ev_cnt},
        {48'h0, 32'd4, 32'd4});

    for (int i = 0; i < 4; i++) pkt(1'b0, 8'hFF, 1'b1);
    drive(1'b0);
    drive(1'b0);
    drive(1'b1);
    drive(1'b1);
    drive(1'b0);
    @(negedge clk);
    rst = 1'b1;
    sin = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);
    frame(0, 0, 8'h0B);
    settle();
    chk("rst_mid", {16'h0, dv_cnt, ev_cnt},
        {16'h0, 32'd5, 32'd4});

    pkt(1'b0, 8'h55, 1'b0);
    settle();
    chk("bad_stop", {45'h0, err_flags, ev_cnt},
        {45'h0, 3'b100, 32'd5});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
